uart_rx: RTL and testbench



---
 rtl/uart_rx.sv | 150 +++++++++++++++
 tb/tb_uart_rx.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames, 16x oversampling with a 3-sample majority vote at mid-bit.
// Delivers each good byte with a one-cycle Rx_Done pulse; a low stop bit gives Frame_Err.
module uart_rx #(
  parameter logic IDLE_VALUE  = 1'b1,
  parameter logic START_VALUE = 1'b0
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [2:0] Baudrate_Set,
  input  logic       data_rx,
  output logic [7:0] data,
  output logic       Rx_Done,
  output logic       Frame_Err,
  output logic       Rx_Busy
);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e     r_state;
  logic       r_sync1, r_sync2, r_sync3;
  logic       r_live, r_armed;
  logic [2:0] r_baud;
  logic [8:0] r_div_cnt;
  logic [3:0] r_smp_cnt;
  logic [2:0] r_bit_idx;
  logic [1:0] r_vote;
  logic [7:0] r_shift;

  logic [8:0] w_div_max;
  logic [2:0] w_samples;
  logic       w_fall, w_tick, w_vote_now, w_wrap, w_bit;

  // r_armed: the line has really been seen high since reset, so a line held low
  // out of reset cannot fake a start edge against the flops' reset value.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_sync3 <= 1'b1;
      r_live  <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_sync1 <= data_rx;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_live  <= 1'b1;
      r_armed <= r_armed | (r_live & r_sync1);
    end
  end

  assign w_fall = r_armed & r_sync3 & ~r_sync2;

  always_comb begin
    case (r_baud)
      3'd1:    w_div_max = 9'd161;
      3'd2:    w_div_max = 9'd80;
      3'd3:    w_div_max = 9'd53;
      3'd4:    w_div_max = 9'd26;
      default: w_div_max = 9'd324;
    endcase
  end

  assign w_tick     = (r_state != StIdle) && (r_div_cnt == w_div_max);
  assign w_vote_now = w_tick && (r_smp_cnt == 4'd8);
  assign w_wrap     = w_tick && (r_smp_cnt == 4'd15);
  // Samples from smp_cnt 6 and 7 plus the current one at 8.
  assign w_samples  = {r_vote, r_sync2};
  assign w_bit      = (w_samples[2] & w_samples[1]) | (w_samples[2] & w_samples[0]) |
                      (w_samples[1] & w_samples[0]);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= StIdle;
      r_baud    <= 3'd0;
      r_div_cnt <= 9'd0;
      r_smp_cnt <= 4'd0;
      r_bit_idx <= 3'd0;
      r_vote    <= 2'd0;
      r_shift   <= 8'd0;
      data      <= 8'd0;
      Rx_Done   <= 1'b0;
      Frame_Err <= 1'b0;
      Rx_Busy   <= 1'b0;
    end else begin
      Rx_Done   <= 1'b0;
      Frame_Err <= 1'b0;

      if (r_state == StIdle) begin
        r_div_cnt <= 9'd0;
        r_smp_cnt <= 4'd0;
      end else if (w_tick) begin
        r_div_cnt <= 9'd0;
        r_smp_cnt <= r_smp_cnt + 4'd1;
      end else begin
        r_div_cnt <= r_div_cnt + 9'd1;
      end

      if (w_tick && (r_smp_cnt == 4'd6 || r_smp_cnt == 4'd7)) begin
        r_vote <= {r_vote[0], r_sync2};
      end

      unique case (r_state)
        StIdle: begin
          if (w_fall) begin
            r_state   <= StStart;
            r_baud    <= Baudrate_Set;
            r_bit_idx <= 3'd0;
            Rx_Busy   <= 1'b1;
          end
        end
        StStart: begin
          if (w_vote_now && (w_bit != START_VALUE)) begin
            r_state <= StIdle;
            Rx_Busy <= 1'b0;
          end else if (w_wrap) begin
            r_state   <= StData;
            r_bit_idx <= 3'd0;
          end
        end
        StData: begin
          if (w_vote_now) begin
            r_shift[r_bit_idx] <= w_bit;
          end
          if (w_wrap) begin
            if (r_bit_idx == 3'd7) begin
              r_state <= StStop;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end
        end
        StStop: begin
          // Leave at mid stop bit so a back-to-back start edge is caught.
          if (w_vote_now) begin
            if (w_bit == IDLE_VALUE) begin
              data    <= r_shift;
              Rx_Done <= 1'b1;
            end else begin
              Frame_Err <= 1'b1;
            end
            r_state <= StIdle;
            Rx_Busy <= 1'b0;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: the driver pushes the expected outcome of each frame,
// and a monitor pops and checks it whenever Rx_Done or Frame_Err pulses.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [2:0] Baudrate_Set = 3'd4;
  logic       data_rx = 1'b1;
  logic [7:0] data;
  logic       Rx_Done, Frame_Err, Rx_Busy;

  uart_rx dut (
    .clk         (clk),
    .rstn        (rstn),
    .Baudrate_Set(Baudrate_Set),
    .data_rx     (data_rx),
    .data        (data),
    .Rx_Done     (Rx_Done),
    .Frame_Err   (Frame_Err),
    .Rx_Busy     (Rx_Busy)
  );

  always #10 clk = ~clk;

  typedef struct {
    bit         err;
    logic [7:0] b;
    int         s;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_near(input string name, input int act, input int exp, input int tol);
    checks++;
    if (act < exp - tol || act > exp + tol) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d +/- %0d", name, act, exp, tol);
    end
  endtask

  function automatic int baud_of(input logic [2:0] sel);
    case (sel)
      3'd1:    return 19200;
      3'd2:    return 38400;
      3'd3:    return 57600;
      3'd4:    return 115200;
      default: return 9600;
    endcase
  endfunction

  function automatic int s_of(input logic [2:0] sel);
    return 1_000_000_000 / baud_of(sel) / 20 / 16;
  endfunction

  function automatic int bitclk_of(input logic [2:0] sel);
    return 50_000_000 / baud_of(sel);
  endfunction

  // Drives a frame at the nominal bit rate; spikes flip the line for one clock exactly
  // where the receiver takes sample 7 of each data bit.
  task automatic drive_frame(input logic [7:0] b, input logic [2:0] sel, input logic stop_lvl,
                             input bit spikes, input int ncyc, input logic [2:0] sel_mid);
    int bc, s, total;
    bc = bitclk_of(sel);
    s = s_of(sel);
    total = (ncyc > 0) ? ncyc : 10 * bc;
    Baudrate_Set = sel;
    for (int n = 0; n < total; n++) begin
      int   idx;
      logic lvl;
      idx = n / bc;
      if (idx == 0) lvl = 1'b0;
      else if (idx <= 8) lvl = b[idx-1];
      else lvl = stop_lvl;
      if (spikes) begin
        for (int i = 0; i < 8; i++) begin
          if (n == (16 * (i + 1) + 8) * s) lvl = ~lvl;
        end
      end
      if (n == bc) Baudrate_Set = sel_mid;
      @(posedge clk);
      #1;
      data_rx = lvl;
    end
  endtask

  task automatic send(input logic [7:0] b, input logic [2:0] sel, input logic stop_lvl,
                      input bit spikes, input logic [2:0] sel_mid);
    exp_t e;
    e.err = (stop_lvl != 1'b1);
    e.b   = b;
    e.s   = s_of(sel);
    sb_q.push_back(e);
    drive_frame(b, sel, stop_lvl, spikes, 0, sel_mid);
  endtask

  task automatic idle(input int n);
    data_rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor
  initial begin
    int         cyc;
    int         t_start;
    logic       prev_busy, prev_done, prev_err;
    logic [7:0] last_good;
    exp_t       e;
    cyc = 0;
    t_start = 0;
    prev_busy = 1'b0;
    prev_done = 1'b0;
    prev_err = 1'b0;
    last_good = 8'd0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rstn) begin
        last_good = 8'd0;
        prev_busy = 1'b0;
        prev_done = 1'b0;
        prev_err  = 1'b0;
      end else begin
        if (Rx_Busy && !prev_busy) t_start = cyc;
        if (Rx_Done || Frame_Err) begin
          chk("done_err_exclusive", int'(Rx_Done && Frame_Err), 0);
          chk("pulse_width", int'((Rx_Done && prev_done) || (Frame_Err && prev_err)), 0);
          chk("busy_low_at_pulse", int'(Rx_Busy), 0);
          chk("pulse_expected", int'(sb_q.size() > 0), 1);
          if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("pulse_kind_err", int'(Frame_Err), int'(e.err));
            chk("data", int'(data), e.err ? int'(last_good) : int'(e.b));
            chk_near("latency", cyc - t_start, 153 * e.s, 3);
            if (!e.err) last_good = e.b;
          end
        end
        prev_busy = Rx_Busy;
        prev_done = Rx_Done;
        prev_err  = Frame_Err;
      end
    end
  end

  // Stimulus
  initial begin
    int bc4;
    bc4 = bitclk_of(3'd4);

    rstn = 1'b0;
    data_rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", int'(data), 0);
    chk("rst_done", int'(Rx_Done), 0);
    chk("rst_err", int'(Frame_Err), 0);
    chk("rst_busy", int'(Rx_Busy), 0);

    // Line held low through reset release must not start a frame.
    data_rx = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (600) @(posedge clk);
    #1;
    chk("low_from_reset_busy", int'(Rx_Busy), 0);
    idle(20);

    // 200-clock glitch at every baud setting; busy length exposes the divider.
    for (int sel = 0; sel < 8; sel++) begin
      int cnt;
      cnt = 0;
      Baudrate_Set = 3'(sel);
      data_rx = 1'b0;
      for (int i = 0; i < 9 * s_of(3'(sel)) + 400; i++) begin
        @(posedge clk);
        #1;
        if (i == 199) data_rx = 1'b1;
        if (Rx_Busy) cnt++;
      end
      chk_near("glitch_busy_len", cnt, 9 * s_of(3'(sel)), 3);
      chk("glitch_busy_end", int'(Rx_Busy), 0);
    end

    send(8'hA5, 3'd4, 1'b1, 1'b0, 3'd4);
    idle(bc4);
    send(8'h3C, 3'd4, 1'b0, 1'b0, 3'd4);
    idle(bc4);
    send(8'h5A, 3'd4, 1'b1, 1'b1, 3'd4);
    idle(bc4);
    send(8'h00, 3'd4, 1'b1, 1'b0, 3'd4);
    send(8'hFF, 3'd4, 1'b1, 1'b0, 3'd4);
    idle(bc4);

    // Reset in the middle of data bit 4; nothing is expected from this frame.
    drive_frame(8'hC3, 3'd4, 1'b1, 1'b0, 5 * bc4 + 200, 3'd4);
    chk("busy_before_reset", int'(Rx_Busy), 1);
    rstn = 1'b0;
    #1;
    chk("midreset_data", int'(data), 0);
    chk("midreset_busy", int'(Rx_Busy), 0);
    chk("midreset_done", int'(Rx_Done), 0);
    chk("midreset_err", int'(Frame_Err), 0);
    data_rx = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rstn = 1'b1;
    idle(50);
    send(8'h81, 3'd4, 1'b1, 1'b0, 3'd4);
    idle(bc4);

    // Random bytes, occasional bad stop bit, baud select changed mid-frame.
    for (int k = 0; k < 3; k++) begin
      logic [7:0] b;
      logic       stop;
      b = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      send(b, 3'd4, stop, 1'b0, 3'($urandom_range(0, 7)));
      idle(bc4);
    end

    for (int i = 0; i < 2000 && sb_q.size() > 0; i++) @(posedge clk);
    chk("scoreboard_drained", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
